hazard_ctrl: RTL and testbench

//  Hazard scheduler for the 5-stage pipeline. Drives the F/D/E/M stall, flush and forwarding selects.

---
 rtl/pipeline_pkg.sv | 8 +
 rtl/sat_counter.sv | 14 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared encodings for the pipeline hazard scheduler
package pipeline_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hz_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         En,
  input  logic         Clk,
  input  logic         Rst,
  output logic [W-1:0] Q
);
  always_ff @(posedge Clk) begin
    if (Rst) Q <= '0;
    else if (En && !(&Q)) Q <= Q + 1'b1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control with memory-wait timeout and perf counters
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int RA_W = 5,
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [RA_W-1:0]  RsD,
  input  logic [RA_W-1:0]  RtD,
  input  logic [RA_W-1:0]  RsE,
  input  logic [RA_W-1:0]  RtE,
  input  logic [RA_W-1:0]  WriteRegE,
  input  logic [RA_W-1:0]  WriteRegM,
  input  logic [RA_W-1:0]  WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [RA_W-1:0] RZ = RA_W'(REG_ZERO);
  hz_state_t state;
  logic [TW-1:0] timer;
  logic err_q, lw, br, mw, hold;
  logic [CNT_W-1:0] stall_q, flush_q;
  function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a == b) && (a != RZ);
  endfunction
  // every output is forced inactive while Rst is high
  always_comb begin
    lw = MemToRegE & (hit(WriteRegE, RsD) | hit(WriteRegE, RtD));
    br = BranchD & ((RegWriteE & (hit(WriteRegE, RsD) | hit(WriteRegE, RtD)))
                  | (MemToRegM & (hit(WriteRegM, RsD) | hit(WriteRegM, RtD))));
    mw = MemReqM & ~MemReadyM & (state != ERROR);
    hold = ~Rst & (mw | (state == ERROR));
    StallF = ~Rst & (lw | br | hold);
    StallD = StallF;
    StallE = hold;
    StallM = hold;
    FlushW = hold;
    FlushE = ~Rst & (lw | br) & ~hold;
    FlushD = ~Rst & PCSrcD & ~StallF;
    ForwardAD = ~Rst & RegWriteM & hit(WriteRegM, RsD);
    ForwardBD = ~Rst & RegWriteM & hit(WriteRegM, RtD);
    ForwardAE = Rst ? FWD_RF : (RegWriteM & hit(WriteRegM, RsE)) ? FWD_MEM :
                (RegWriteW & hit(WriteRegW, RsE)) ? FWD_WB : FWD_RF;
    ForwardBE = Rst ? FWD_RF : (RegWriteM & hit(WriteRegM, RtE)) ? FWD_MEM :
                (RegWriteW & hit(WriteRegW, RtE)) ? FWD_WB : FWD_RF;
    MemErr = ~Rst & err_q;
    StallCnt = Rst ? '0 : stall_q;
    FlushCnt = Rst ? '0 : flush_q;
  end
  // ready takes priority over the timeout check in the same cycle
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
      timer <= '0;
      err_q <= 1'b0;
    end else if (state == RUN && mw) begin
      state <= MEM_WAIT;
      timer <= TW'(1);
    end else if (state == MEM_WAIT) begin
      if (MemReadyM) begin
        state <= RUN;
        timer <= '0;
      end else if (timer == TW'(MEM_TIMEOUT)) begin
        state <= ERROR;
        err_q <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
  sat_counter #(CNT_W) u_stall_cnt (.En(StallF), .Clk(Clk), .Rst(Rst), .Q(stall_q));
  sat_counter #(CNT_W) u_flush_cnt (.En(FlushD | FlushE), .Clk(Clk), .Rst(Rst), .Q(flush_q));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with queued expectations checked by a negedge monitor
module tb_hazard_ctrl;
  logic Clk = 1'b0, Rst = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD, PCSrcD, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAD, ForwardBD, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [2:0] StallCnt, FlushCnt;
  typedef struct {
    logic [3:0] st;
    logic [2:0] fl;
    logic [5:0] fw;
    logic err;
    logic [2:0] sc;
    logic [2:0] fc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, sc = 0, fc = 0;

  hazard_ctrl #(.RA_W(5), .CNT_W(3), .MEM_TIMEOUT(4)) dut (
    .Clk(Clk), .Rst(Rst), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("stall", {4'b0, StallF, StallD, StallE, StallM}, {4'b0, e.st});
      cmp("flush", {5'b0, FlushD, FlushE, FlushW}, {5'b0, e.fl});
      cmp("fwd", {2'b0, ForwardAD, ForwardBD, ForwardAE, ForwardBE}, {2'b0, e.fw});
      cmp("memerr", {7'b0, MemErr}, {7'b0, e.err});
      cmp("stallcnt", {5'b0, StallCnt}, {5'b0, e.sc});
      cmp("flushcnt", {5'b0, FlushCnt}, {5'b0, e.fc});
    end
  end

  task automatic clr();
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD, PCSrcD, MemReqM, MemReadyM} = '0;
  endtask

  // counter expectations follow the hand-written stall/flush columns of earlier vectors
  task automatic chk(input logic [3:0] st, input logic [2:0] fl, input logic [5:0] fw, input logic err);
    exp_t e;
    e.st = st; e.fl = fl; e.fw = fw; e.err = err;
    e.sc = Rst ? 3'd0 : 3'(sc);
    e.fc = Rst ? 3'd0 : 3'(fc);
    q.push_back(e);
    if (Rst) begin
      sc = 0; fc = 0;
    end else begin
      if (st[3] && sc < 7) sc++;
      if ((fl[2] | fl[1]) && fc < 7) fc++;
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge Clk);
    #1;
    MemReqM = 1; MemToRegE = 1; WriteRegE = 5; RtD = 5; RegWriteM = 1; WriteRegM = 3; RsE = 3;
    chk(4'b0000, 3'b000, 6'b000000, 0);
    Rst = 0; clr();
    chk(4'b0000, 3'b000, 6'b000000, 0);
    RegWriteM = 1; WriteRegM = 3; RsE = 3; RegWriteW = 1; WriteRegW = 3;
    chk(4'b0000, 3'b000, 6'b001000, 0);
    clr(); RegWriteW = 1; WriteRegW = 4; RtE = 4;
    chk(4'b0000, 3'b000, 6'b000001, 0);
    clr(); RegWriteM = 1; WriteRegM = 6; RsD = 6; RtD = 6;
    chk(4'b0000, 3'b000, 6'b110000, 0);
    clr(); MemToRegE = 1; WriteRegE = 5; RtD = 5;
    chk(4'b1100, 3'b010, 6'b000000, 0);
    clr(); BranchD = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7; PCSrcD = 1;
    chk(4'b1100, 3'b010, 6'b000000, 0);
    clr(); BranchD = 1; PCSrcD = 1;
    chk(4'b0000, 3'b100, 6'b000000, 0);
    clr(); BranchD = 1; MemToRegM = 1; WriteRegM = 9; RtD = 9;
    chk(4'b1100, 3'b010, 6'b000000, 0);
    clr(); RegWriteE = 1; RegWriteM = 1; RegWriteW = 1; MemToRegE = 1; MemToRegM = 1; BranchD = 1;
    chk(4'b0000, 3'b000, 6'b000000, 0);
    clr(); MemReqM = 1; MemToRegE = 1; WriteRegE = 5; RsD = 5;
    chk(4'b1111, 3'b001, 6'b000000, 0);
    clr(); MemReqM = 1;
    chk(4'b1111, 3'b001, 6'b000000, 0);
    chk(4'b1111, 3'b001, 6'b000000, 0);
    MemReadyM = 1;
    chk(4'b0000, 3'b000, 6'b000000, 0);
    clr();
    chk(4'b0000, 3'b000, 6'b000000, 0);
    MemReqM = 1;
    for (int i = 0; i < 5; i++) chk(4'b1111, 3'b001, 6'b000000, 0);
    for (int i = 0; i < 2; i++) chk(4'b1111, 3'b001, 6'b000000, 1);
    MemReqM = 0; MemReadyM = 1;
    chk(4'b1111, 3'b001, 6'b000000, 1);
    Rst = 1;
    chk(4'b0000, 3'b000, 6'b000000, 0);
    Rst = 0; clr();
    chk(4'b0000, 3'b000, 6'b000000, 0);
    MemReqM = 1;
    chk(4'b1111, 3'b001, 6'b000000, 0);
    chk(4'b1111, 3'b001, 6'b000000, 0);
    Rst = 1;
    chk(4'b0000, 3'b000, 6'b000000, 0);
    Rst = 0; clr();
    chk(4'b0000, 3'b000, 6'b000000, 0);
    MemToRegE = 1; WriteRegE = 5; RtD = 5; PCSrcD = 1;
    chk(4'b1100, 3'b010, 6'b000000, 0);
    clr();
    chk(4'b0000, 3'b000, 6'b000000, 0);
    repeat (3) @(posedge Clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
